// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

    // Width of the port I starvation counter; holds MAX_WAIT values 1..15.
    localparam int CNT_W = 4;

    // Owner of the memory access issued in the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_RD_I = 2'd1,
        OWN_RD_D = 2'd2,
        OWN_WR   = 2'd3
    } own_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fixed-priority arbiter with starvation guard for a single-port memory
//
// Shares one registered-read memory between instruction fetch (port I, read
// only) and load/store (port D, read/write). Port D wins by default; after
// MAX_WAIT consecutive denied port I cycles, port I is forced through.
// Read data returns one cycle after the grant, routed to the owning port.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   i_req/i_addr             port I read request (held until i_gnt)
//   i_gnt                    port I accepted this cycle (combinational)
//   i_rvalid/i_rdata         port I read return, one cycle after grant
//   d_req/d_we/d_addr/d_wdata port D request
//   d_gnt                    port D accepted this cycle (combinational)
//   d_rvalid/d_rdata         port D read return, one cycle after read grant
//   mem_wen/mem_addr/mem_wdata memory command
//   mem_rdata                memory data for the address of the previous cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    own_e             own_q,      own_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             force_i;

    always_comb begin
        force_i    = (wait_cnt_q == MAX_WAIT_C);
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        mem_addr   = mem_addr_q;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        own_d      = OWN_IDLE;
        wait_cnt_d = wait_cnt_q;

        // No grants while reset is held, so nothing reaches memory.
        if (rst) begin
            if (force_i && i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end

        if (i_gnt) begin
            mem_addr = i_addr;
            own_d    = OWN_RD_I;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wen   = d_we;
            mem_wdata = d_wdata;
            own_d     = d_we ? OWN_WR : OWN_RD_D;
        end

        // Idle cycles keep the last granted address on the memory bus.
        mem_addr_d = mem_addr;

        if (!i_req || i_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            own_q      <= OWN_IDLE;
            wait_cnt_q <= '0;
            mem_addr_q <= '0;
        end else begin
            own_q      <= own_d;
            wait_cnt_q <= wait_cnt_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Masking with rst drops a read that was in flight when reset arrives.
    always_comb begin
        i_rvalid = rst && (own_q == OWN_RD_I);
        d_rvalid = rst && (own_q == OWN_RD_D);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read address, write at the rising edge.
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] mem_raddr = '0;
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
        mem_raddr <= mem_addr;
    end
    assign mem_rdata = mem[mem_raddr[7:0]];

    // Reference contents, updated only from the bench's expected writes.
    logic [DW-1:0] ref_mem [0:255];

    typedef struct {
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        int            exp_gnt;   // 0 none, 1 port I, 2 port D
    } vec_t;

    typedef struct {
        logic          i_rv;
        logic          d_rv;
        logic [DW-1:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [AW-1:0] last_addr = '0;

    function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                                logic [AW-1:0] da, logic [DW-1:0] dd, int g);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.exp_gnt = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " i_gnt"},    i_gnt,    0);
        chk({tag, " d_gnt"},    d_gnt,    0);
        chk({tag, " mem_wen"},  mem_wen,  0);
        chk({tag, " i_rvalid"}, i_rvalid, 0);
        chk({tag, " d_rvalid"}, d_rvalid, 0);
        chk({tag, " i_rdata"},  i_rdata,  0);
        chk({tag, " d_rdata"},  d_rdata,  0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic eg_i, eg_d;
        rsp_t e;
        string t;
        t = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        @(negedge clk);
        eg_i = (v.exp_gnt == 1);
        eg_d = (v.exp_gnt == 2);
        chk({t, " i_gnt"},   i_gnt,   eg_i);
        chk({t, " d_gnt"},   d_gnt,   eg_d);
        chk({t, " mem_wen"}, mem_wen, eg_d && v.d_we);
        if (eg_i) last_addr = v.i_addr;
        if (eg_d) last_addr = v.d_addr;
        chk({t, " mem_addr"}, mem_addr, last_addr);
        if (eg_d && v.d_we) begin
            chk({t, " mem_wdata"}, mem_wdata, v.d_wdata);
            ref_mem[v.d_addr[7:0]] = v.d_wdata;
        end else if (!eg_i && !eg_d) begin
            chk({t, " mem_wdata"}, mem_wdata, 0);
        end
        // Return for the previous cycle's grant.
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{i_rv: 1'b0, d_rv: 1'b0, data: '0};
        chk({t, " i_rvalid"}, i_rvalid, e.i_rv);
        chk({t, " d_rvalid"}, d_rvalid, e.d_rv);
        chk({t, " i_rdata"},  i_rdata,  e.i_rv ? e.data : 16'h0);
        chk({t, " d_rdata"},  d_rdata,  e.d_rv ? e.data : 16'h0);
        // Expectation for this cycle's grant.
        e.i_rv = eg_i;
        e.d_rv = eg_d && !v.d_we;
        e.data = ref_mem[last_addr[7:0]];
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 16'h0101) ^ 16'hA5A5;
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
        end
        mem[8'h10]     = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;

        // Reset with both ports requesting.
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 16'h0007; d_addr = 16'h0009; d_wdata = 16'hDEAD;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("reset%0d", c));
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // First grant after reset goes to D.
        vecs.push_back(mk(1, 16'h0030, 1, 0, 16'h0005, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));
        // Single port I read.
        vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));
        // Write then read of the same address.
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 2));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0020, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));
        // Continuous contention: D D D I, twice.
        vecs.push_back(mk(1, 16'h0030, 1, 0, 16'h0041, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0030, 1, 0, 16'h0042, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0030, 1, 0, 16'h0043, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0030, 1, 0, 16'h0044, 16'h0, 1));
        vecs.push_back(mk(1, 16'h0031, 1, 0, 16'h0045, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0031, 1, 0, 16'h0046, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0031, 1, 0, 16'h0047, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0031, 1, 0, 16'h0048, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));
        // Back-to-back alternating reads.
        vecs.push_back(mk(1, 16'h0001, 0, 0, 16'h0000, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0002, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0003, 0, 0, 16'h0000, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0004, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));
        // Port I drops its request before grant: counter restarts.
        vecs.push_back(mk(1, 16'h0050, 1, 0, 16'h0061, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 0, 16'h0062, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0063, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 1, 16'h0064, 16'h7777, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 0, 16'h0064, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 0, 16'h0065, 16'h0, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 0, 16'h0066, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset arriving while a D read is outstanding.
        apply(mk(0, 16'h0000, 1, 0, 16'h0020, 16'h0, 2), 100);
        @(posedge clk);
        #1 rst = 1'b0; i_req = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst0");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midrst1");
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("postrst");
        last_addr = '0;
        chk("postrst mem_addr", mem_addr, last_addr);

        // Normal operation resumes after reset.
        apply(mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0, 1), 101);
        apply(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0, 0), 102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `memory` block between instruction fetch (port I) and load/store (port D) in miCPU. It grants at most one access per cycle and drives the memory's address, write-enable and write-data. Because the memory registers its read address, the arbiter routes each read result back to the owning port one cycle after the grant. Port D has fixed priority, with a starvation counter that forces a port I grant after `MAX_WAIT` consecutive denials.

## Interface
- `AW`, 16: address width; matches `ISIZE`.
- `DW`, 16: data width; matches `DSIZE`.
- `MAX_WAIT`, 3: consecutive denied port I cycles before port I gets priority (1..15).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  port I request; held with `i_addr` until `i_gnt`.
- `i_addr`  in  AW  port I read address.
- `i_gnt`  out  1  port I request accepted this cycle (combinational).
- `i_rvalid`  out  1  `i_rdata` valid (registered).
- `i_rdata`  out  DW  port I read data.
- `d_req`  in  1  port D request.
- `d_we`  in  1  port D write when 1, read when 0.
- `d_addr`  in  AW  port D address.
- `d_wdata`  in  DW  port D write data.
- `d_gnt`  out  1  port D request accepted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid; reads only (registered).
- `d_rdata`  out  DW  port D read data.
- `mem_wen`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; reflects the address presented in the previous cycle.

## Operation
- Arbitration is combinational each cycle:
  - If `force_i` (`wait_cnt == MAX_WAIT`) and `i_req`: grant I.
  - Else if `d_req`: grant D.
  - Else if `i_req`: grant I.
  - Otherwise grant nothing.
- `i_gnt` and `d_gnt` are mutually exclusive.
- Memory muxing:
  - Port I grant: `mem_addr=i_addr`, `mem_wen=0`.
  - Port D grant: `mem_addr=d_addr`, `mem_wen=d_we`, `mem_wdata=d_wdata`.
  - No grant: `mem_addr` holds its last granted value, `mem_wen=0`, `mem_wdata=0`.
- `mem_wen` is asserted only in a cycle with `d_gnt & d_we`.
- Owner register `own`, updated every cycle:
  - States IDLE, RD_I, RD_D, WR.
  - Next state: RD_I on a port I grant; RD_D on a port D read grant; WR on a port D write grant; otherwise IDLE.
- Return routing:
  - `i_rvalid = (own == RD_I)`, with `i_rdata = mem_rdata`.
  - `d_rvalid = (own == RD_D)`, with `d_rdata = mem_rdata`.
  - A port whose `rvalid` is low sees 0 on its `rdata`.
  - WR produces no `rvalid`.
- Starvation counter `wait_cnt`, width 4:
  - Increments, saturating at `MAX_WAIT`, in each cycle where `i_req & !i_gnt`.
  - Clears on `i_gnt` or on `!i_req`.
- Back-to-back grants are allowed every cycle, so read throughput is 1 per cycle.
- Write then read of the same address in consecutive cycles returns the new data, since memory has already written it.
- Simultaneous `i_req` and `d_req` with `wait_cnt < MAX_WAIT`: D is granted, and I waits while holding its request.
- Requester dropping `req` before grant: legal; the counter clears.

## Timing
- Grant latency: 0 cycles (same cycle as the qualifying `req`).
- Read data latency: `rvalid` is asserted exactly 1 cycle after the grant.
- Write completes at the rising edge that ends the grant cycle.
- Reset (`rst == 0` sampled at a rising edge) sets:
  - `own = IDLE`, `wait_cnt = 0`, `mem_addr` register = 0.
  - Both `rvalid` = 0 and both `rdata` = 0 in the following cycle.
  - Both `gnt` = 0 and `mem_wen` = 0 while `rst == 0`.
- Reset in the middle of an outstanding read drops that read's `rvalid`; requesters must reissue.
- Worst-case port I wait under continuous `d_req`: `MAX_WAIT` cycles, then a guaranteed grant.

## Structure
- Owner state encoding (IDLE=0, RD_I=1, RD_D=2, WR=3) and counter width go in `define.v`, next to `ISIZE` and `DSIZE`.
- A single module, no sub-modules; the starvation counter is small enough to stay inline.
- The top level instantiates `mem_arbiter` between the fetch/LSU stages and `memory`:
  - `mem_wen`, `mem_addr` and `mem_wdata` connect to `memory`'s `wen`, `addr` and `data_in`.
  - `memory`'s `data_out` connects to `mem_rdata`.
  - `memory`'s own active-high init reset is driven as `~rst`.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles with both `req=1`. Required: both `gnt=0`, `mem_wen=0`, both `rvalid=0`; after release, the first grant goes to D.
- **Single read:** `i_req=1`, `i_addr=0x0010`, memory[0x0010]=0xBEEF. Required: `i_gnt=1` in cycle 0; `i_rvalid=1` with `i_rdata=0xBEEF` in cycle 1; `d_rvalid=0`.
- **Write then read:** D write 0x0020 ← 0x1234, then D read 0x0020 in the next cycle. Required: `mem_wen=1` only in the first cycle; `d_rvalid=1` with `d_rdata=0x1234` one cycle after the read grant.
- **Contention and starvation:** `d_req` and `i_req` held high continuously with `MAX_WAIT=3`. Required: D is granted in cycles 0–2 and I in cycle 3; the pattern then repeats, and each grant's `rvalid` is routed to the correct port.
- **Back-to-back alternating reads:** interleave I and D reads at addresses 0x0001–0x0004. Required: one `rvalid` per cycle, on the correct port, with correct data, and no bubbles.
- **Reset mid-read:** D read granted, with `rst=0` asserted in the following cycle. Required: `d_rvalid` stays 0, and `own` returns to IDLE.
